adder_tree_sched: RTL and testbench
===================================

Name: adder_tree_sched

Overview:
Scheduler that shares one pipelined 8-input adder tree among NREQ requesters. Each requester presents eight packed operands. The block grants access round-robin, issues one operand vector per cycle into the tree, and tracks requester tags through the tree latency. It returns each sum to the originating requester in a hold register, released by acknowledge. It sits between client logic and the three-stage adder datapath (stage1/stage2/stage3 adders).

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, operand width; sum width SW = DW+3
LATENCY, 3, cycles from tree_valid high to tree_sum valid (matches 3 registered adder stages)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req  in  NREQ  per-requester request, level
req_data  in  NREQ*8*DW  requester i operands at [i*8*DW +: 8*DW]; operand k at [k*DW +: DW] within that slice
gnt  out  NREQ  one-hot grant pulse; data accepted this cycle
tree_valid  out  1  operand vector valid to datapath (registered)
tree_in  out  8*DW  operands to datapath (registered)
tree_sum  in  SW  datapath result
rsp_valid  out  NREQ  result held for requester i
rsp_sum  out  NREQ*SW  held result, requester i at [i*SW +: SW]
rsp_ack  in  NREQ  requester consumes result
busy  out  1  any tag in flight or any rsp_valid set

Behaviour:
- Reset (sync, dominant over all other inputs): gnt=0, tree_valid=0, tree_in=0, rsp_valid=0, rsp_sum=0, busy=0. Round-robin pointer=0. All pending flags and tag pipeline cleared.
- pending[i] is set on gnt[i] and cleared at the edge where rsp_ack[i] && rsp_valid[i].
- Eligibility: eligible[i] = req[i] && !pending[i], evaluated on registered pending. A requester is regranted at earliest the cycle after its ack. At most one request is outstanding per requester.
- Arbitration: gnt is combinational from eligible and pointer. Search starts at the pointer index and wraps modulo NREQ. The first eligible index wins. After granting i, pointer <= (i+1) mod NREQ. With no grant, the pointer holds.
- Issue: on gnt[i] at cycle T, tree_in <= req_data slice i and tree_valid <= 1 at T+1. Otherwise tree_valid <= 0 and tree_in holds its value.
- Tag pipeline: LATENCY-deep shift register of {valid, index}, loaded from the issue. When the tail is valid, tree_sum is captured into rsp_sum[index] and rsp_valid[index] <= 1.
- Latency: grant at T -> rsp_valid at T+2+LATENCY (T+5 by default). Throughput is 1 vector/cycle when different requesters alternate.
- rsp_valid[i] and rsp_sum[i] hold until ack. Ack while rsp_valid[i]=0 is ignored. Capture and ack can never coincide for the same requester, because pending blocks a new grant.
- Sum arithmetic is unsigned, SW bits, and cannot overflow. Max is 8*(2^DW-1) = 0x7F8 for DW=8.
- Reset mid-operation: in-flight tags are discarded. Any tree_sum arriving afterwards is ignored because tag valid bits are clear.
- req deasserted after grant has no effect on the outstanding transaction.
- busy = |tag_valid | |rsp_valid, registered-equivalent; 0 after reset.

Optional Feature:
ADDER_TREE_SCHED_STATS_EN:
- Defined: adds outputs issue_cnt[15:0] and stall_cnt[15:0], both cleared by rst and saturating at 0xFFFF.
  - issue_cnt increments on any grant.
  - stall_cnt increments each cycle with |req && gnt==0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then requester 0 sends operands 01,02,...,08 and grant at T -> gnt=0001 at T; tree_valid at T+1; rsp_valid[0]=1 at T+5 with rsp_sum[0]=0x024, held until rsp_ack[0].
- Requester 2 sends all operands 0xFF -> rsp_sum[2]=0x7F8, no truncation.
- All four requesters request continuously, acking immediately:
  - grants in order 0,1,2,3,0,... one per cycle;
  - each requester regranted only after its ack;
  - results route to the correct index.
- Requester 1 withholds ack for 10 cycles -> never regranted during that time; others continue; rsp_sum[1] is stable; after ack, requester 1 is granted on the next eligible cycle.
- Assert rst two cycles after a grant -> all outputs 0 next edge; the later datapath tree_sum does not set rsp_valid; pointer restarts at requester 0.
- With ADDER_TREE_SCHED_STATS_EN: 5 grants plus 3 cycles of req-with-no-grant -> issue_cnt=5, stall_cnt=3; forced counts saturate at 0xFFFF.

Source files
------------

// File: rtl/adder_tree_sched.sv
// adder_tree_sched
//   Shares one pipelined 8-input adder tree among NREQ requesters. A
//   round-robin arbiter grants one eligible requester per cycle, its eight
//   operands are registered onto tree_in, and a tag pipeline tracks which
//   requester owns each vector so the returning tree_sum lands in that
//   requester's hold register until acknowledged.
//
//   Parameters: NREQ (2..8) requesters, DW operand width (sum width DW+3),
//               LATENCY registered stages inside the external adder tree.
//
//   Ports:
//     clk, rst    rising-edge clock, synchronous active-high reset
//     req         per-requester level request
//     req_data    requester i operands at [i*8*DW +: 8*DW], operand k at [k*DW +: DW]
//     gnt         one-hot grant (combinational), operands taken this cycle
//     tree_valid  registered operand-vector valid to the datapath
//     tree_in     registered operand vector to the datapath
//     tree_sum    result returning from the datapath
//     rsp_valid   per-requester result held
//     rsp_sum     held result, requester i at [i*(DW+3) +: DW+3]
//     rsp_ack     per-requester result consume
//     busy        any vector in flight or any result held
//
//   Optional: define ADDER_TREE_SCHED_STATS_EN to add the saturating 16-bit
//   counters issue_cnt (grants) and stall_cnt (cycles with a request but no grant).

module adder_tree_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8*DW-1:0]     req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     tree_valid,
  output logic [8*DW-1:0]          tree_in,
  input  logic [DW+2:0]            tree_sum,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [NREQ*(DW+3)-1:0]   rsp_sum,
  input  logic [NREQ-1:0]          rsp_ack,
  output logic                     busy
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [15:0]              issue_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int SW = DW + 3;
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]               ptr_q, ptr_d;
  logic [NREQ-1:0]             pending_q, pending_d;
  logic                        tree_valid_q, tree_valid_d;
  logic [8*DW-1:0]             tree_in_q, tree_in_d;
  logic [PW-1:0]               issue_idx_q, issue_idx_d;
  logic [LATENCY-1:0]          tag_v_q, tag_v_d;
  logic [LATENCY-1:0][PW-1:0]  tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [NREQ*SW-1:0]          rsp_sum_q, rsp_sum_d;

  logic [NREQ-1:0]             eligible;
  logic [NREQ-1:0]             gnt_c;
  logic                        grant_any;
  logic [PW-1:0]               grant_idx;
  logic [PW:0]                 cand;
  logic [8*DW-1:0]             sel_data;

`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [15:0]                 issue_cnt_q, issue_cnt_d;
  logic [15:0]                 stall_cnt_q, stall_cnt_d;
`endif

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    eligible  = req & ~pending_q;
    gnt_c     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!grant_any && eligible[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    // Reset dominates: no grant may be issued while rst is high.
    if (rst) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      gnt_c[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_c[k]) begin
        sel_data = sel_data | req_data[k*8*DW +: 8*DW];
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    tree_valid_d = grant_any;
    tree_in_d    = tree_in_q;
    issue_idx_d  = issue_idx_q;
    if (grant_any) begin
      ptr_d       = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      tree_in_d   = sel_data;
      issue_idx_d = grant_idx;
    end

    // The tag pipe follows the registered issue stage, so its tail lines up
    // with tree_sum LATENCY cycles after tree_valid.
    tag_v_d[0]   = tree_valid_q;
    tag_idx_d[0] = issue_idx_q;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      tag_v_d[k]   = tag_v_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end

    // Capture and ack never coincide for one requester: pending blocks regrant.
    rsp_valid_d = rsp_valid_q & ~rsp_ack;
    rsp_sum_d   = rsp_sum_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (tag_v_q[LATENCY-1] && (tag_idx_q[LATENCY-1] == PW'(k))) begin
        rsp_valid_d[k]        = 1'b1;
        rsp_sum_d[k*SW +: SW] = tree_sum;
      end
    end

    pending_d = (pending_q & ~(rsp_ack & rsp_valid_q)) | gnt_c;
  end

`ifdef ADDER_TREE_SCHED_STATS_EN
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant_any && (issue_cnt_q != '1)) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if ((|req) && !grant_any && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      pending_q    <= '0;
      tree_valid_q <= 1'b0;
      tree_in_q    <= '0;
      issue_idx_q  <= '0;
      tag_v_q      <= '0;
      tag_idx_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_sum_q    <= '0;
`ifdef ADDER_TREE_SCHED_STATS_EN
      issue_cnt_q  <= '0;
      stall_cnt_q  <= '0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      tree_valid_q <= tree_valid_d;
      tree_in_q    <= tree_in_d;
      issue_idx_q  <= issue_idx_d;
      tag_v_q      <= tag_v_d;
      tag_idx_q    <= tag_idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
`ifdef ADDER_TREE_SCHED_STATS_EN
      issue_cnt_q  <= issue_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign gnt        = gnt_c;
  assign tree_valid = tree_valid_q;
  assign tree_in    = tree_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  // The issue stage counts as in flight, so busy covers grant+1 through ack.
  assign busy       = tree_valid_q | (|tag_v_q) | (|rsp_valid_q);
`ifdef ADDER_TREE_SCHED_STATS_EN
  assign issue_cnt  = issue_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
module tb_adder_tree_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SW   = DW + 3;
  localparam int LAT  = 3;
  localparam int VW   = 8 * DW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*VW-1:0]     req_data;
  logic [NREQ-1:0]        gnt;
  logic                   tree_valid;
  logic [VW-1:0]          tree_in;
  logic [SW-1:0]          tree_sum;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ*SW-1:0]     rsp_sum;
  logic [NREQ-1:0]        rsp_ack;
  logic                   busy;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [15:0]            issue_cnt;
  logic [15:0]            stall_cnt;
`endif

  always #5 clk = ~clk;

  adder_tree_sched #(.NREQ(NREQ), .DW(DW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .tree_valid (tree_valid),
    .tree_in    (tree_in),
    .tree_sum   (tree_sum),
    .rsp_valid  (rsp_valid),
    .rsp_sum    (rsp_sum),
    .rsp_ack    (rsp_ack),
    .busy       (busy)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // External three-stage adder tree (part of the environment).
  int unsigned s1[4];
  int unsigned s2[2];
  int unsigned s3;
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      s1[j] <= int'(tree_in[(2*j)*DW +: DW]) + int'(tree_in[(2*j+1)*DW +: DW]);
    s2[0] <= s1[0] + s1[1];
    s2[1] <= s1[2] + s1[3];
    s3    <= s2[0] + s2[1];
  end
  assign tree_sum = s3[SW-1:0];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          idx;
    int unsigned sum;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  bit          m_pend[NREQ];
  int          m_due[NREQ];
  int          m_ptr;
  bit          m_tv;
  logic [VW-1:0] m_tin;
  bit          held[NREQ];
  logic [SW-1:0] held_sum[NREQ];
  int          m_issue, m_stall;

  function automatic int unsigned vec_sum(input logic [VW-1:0] v);
    int unsigned s = 0;
    for (int k = 0; k < 8; k++) s += int'(v[k*DW +: DW]);
    return s;
  endfunction

  always @(negedge clk) begin
    int w, idx;
    logic [NREQ-1:0] exp_gnt, exp_rv;
    bit anyp;
    exp_t e;
    if (rst) begin
      chk("gnt_in_reset", 64'(gnt), 64'd0);
      m_ptr = 0; m_tv = 0; m_tin = '0; m_issue = 0; m_stall = 0;
      for (int i = 0; i < NREQ; i++) begin m_pend[i] = 0; held[i] = 0; end
      sb_q.delete();
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req[idx] && !m_pend[idx]) w = idx;
      end
      exp_gnt = '0;
      if (w >= 0) exp_gnt[w] = 1'b1;
      chk("gnt", 64'(gnt), 64'(exp_gnt));
      chk("tree_valid", 64'(tree_valid), 64'(m_tv));
      chk("tree_in", 64'(tree_in), 64'(m_tin));
      anyp = 0;
      for (int i = 0; i < NREQ; i++) begin
        exp_rv[i] = m_pend[i] && (cyc >= m_due[i]);
        anyp |= m_pend[i];
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("busy", 64'(busy), 64'(anyp));
`ifdef ADDER_TREE_SCHED_STATS_EN
      chk("issue_cnt", 64'(issue_cnt), 64'(m_issue));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && !held[i]) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid[%0d]=1 expected no result (cycle %0d)", i, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_index", 64'(i), 64'(e.idx));
            chk("rsp_sum", 64'(rsp_sum[i*SW +: SW]), 64'(e.sum));
            chk("rsp_latency", 64'(cyc), 64'(e.due));
          end
          held[i] = 1;
          held_sum[i] = rsp_sum[i*SW +: SW];
        end else if (rsp_valid[i] && held[i]) begin
          chk("rsp_hold", 64'(rsp_sum[i*SW +: SW]), 64'(held_sum[i]));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_ack[i] && rsp_valid[i]) held[i] = 0;
        if (rsp_ack[i] && exp_rv[i]) m_pend[i] = 0;
      end
      if (w >= 0) begin
        m_pend[w] = 1;
        m_due[w]  = cyc + 2 + LAT;
        e.idx = w; e.sum = vec_sum(req_data[w*VW +: VW]); e.due = cyc + 2 + LAT;
        sb_q.push_back(e);
        m_ptr = (w + 1) % NREQ;
        m_tv  = 1;
        m_tin = req_data[w*VW +: VW];
        if (m_issue < 65535) m_issue++;
      end else begin
        m_tv = 0;
        if ((|req) && m_stall < 65535) m_stall++;
      end
    end
  end

  // ---------------- ack driver ----------------
  bit              ack_rand;
  logic [NREQ-1:0] ack_hold;
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_hold[i])   rsp_ack[i] = 1'b0;
      else if (ack_rand) rsp_ack[i] = 1'($urandom_range(0, 1));
      else               rsp_ack[i] = rsp_valid[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_data();
    for (int i = 0; i < NREQ*VW/32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  task automatic wait_rsp(input int i, input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid[i]) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_rsp%0d: got no rsp_valid expected one within %0d cycles", i, budget);
    end
  endtask

  task automatic drain();
    bit done = 0;
    @(posedge clk); #1;
    req = '0; ack_rand = 0; ack_hold = '0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; req = '0; req_data = '0; ack_rand = 0; ack_hold = '1; rsp_ack = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tree_valid", 64'(tree_valid), 64'd0);
    chk("reset_tree_in", 64'(tree_in), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Requester 0: operands 1..8 -> 0x024, held until ack.
    ack_hold = 4'b0001;
    req_data[0 +: VW] = 64'h0807060504030201;
    req = 4'b0001;
    @(negedge clk);
    chk("first_gnt", 64'(gnt), 64'h1);
    @(posedge clk); #1;
    req = '0;
    wait_rsp(0, 10, ok);
    if (ok) chk("sum_r0", 64'(rsp_sum[0 +: SW]), 64'h024);
    repeat (3) @(negedge clk);
    chk("held_r0_valid", 64'(rsp_valid[0]), 64'd1);
    chk("held_r0_sum", 64'(rsp_sum[0 +: SW]), 64'h024);
    drain();

    // Requester 2: all 0xFF -> 0x7F8 without truncation.
    ack_hold = 4'b0100;
    req_data[2*VW +: VW] = '1;
    req = 4'b0100;
    @(posedge clk); #1;
    req = '0;
    wait_rsp(2, 10, ok);
    if (ok) chk("sum_r2_max", 64'(rsp_sum[2*SW +: SW]), 64'h7F8);
    drain();

    // All requesting continuously with immediate acks.
    req = '1;
    for (int n = 0; n < 40; n++) begin
      rand_data();
      @(posedge clk); #1;
    end

    // Requester 1 withholds its ack for 10 cycles.
    ack_hold = 4'b0010;
    wait_rsp(1, 20, ok);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      rand_data();
    end
    ack_hold = '0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      rand_data();
    end

    // Random requests and random (sometimes spurious) acks.
    ack_rand = 1;
    for (int n = 0; n < 300; n++) begin
      req = NREQ'($urandom);
      rand_data();
      @(posedge clk); #1;
    end
    drain();

    // Reset two cycles after a grant; the late tree_sum must be ignored.
    req_data[3*VW +: VW] = 64'h1111111111111111;
    req = 4'b1000;
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tree_valid", 64'(tree_valid), 64'd0);
    chk("midrst_tree_in", 64'(tree_in), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    chk("midrst_no_late_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    req = '1;
    @(negedge clk);
    chk("ptr_restart", 64'(gnt), 64'h1);
    drain();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d outstanding expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
